ram_client_port: RTL and testbench

RAM_CLIENT_PORT -- requirements
Module: ram_client_port

---
 rtl/ram_client_port_if.sv | 19 +
 rtl/ram_client_port.sv | 96 +++++++++
 tb/tb_ram_client_port.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_client_port_if.sv
// Ram_if: single-port synchronous RAM bus. The client drives the request side
// and samples data_r one cycle after a read strobe.
`timescale 1ns/1ps
interface Ram_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] addr;
   logic                  en;
   logic                  we;
   logic [BE_W-1:0]       be;
   logic [DATA_WIDTH-1:0] data_w;
   logic [DATA_WIDTH-1:0] data_r;

   modport client (output addr, en, we, be, data_w, input data_r);
   modport memory (input addr, en, we, be, data_w, output data_r);
endinterface

// File: rtl/ram_client_port.sv
// ram_client_port: request/response front end for a synchronous-read RAM.
// Requests pass straight through to the memory port in the accept cycle. Read
// data returns one cycle later and is captured into a small response FIFO.
// Credits (buffered + in-flight reads) bound acceptance so a capture can never
// overflow the FIFO.
`timescale 1ns/1ps
module ram_client_port #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    busy,
   Ram_if.client                   intf
);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RESP_DEPTH);

   logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  inflight_q, inflight_d;

   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [CNT_W:0]        credits_used;

   // Credits count only registered state so req_ready never depends on inputs.
   assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign req_ready    = credits_used < DEPTH_C;
   assign accept       = req_valid && req_ready;

   // Data from a read issued last cycle is on data_r now.
   assign push = inflight_q;
   assign pop  = resp_valid && resp_ready;

   assign resp_valid = count_q != '0;
   assign resp_rdata = fifo_mem[rd_ptr_q];
   assign busy       = inflight_q || resp_valid;

   // Memory port: combinational pass-through of the accepted request.
   assign intf.en     = accept;
   assign intf.we     = accept && req_we;
   assign intf.be     = (accept && req_we) ? req_be : {BE_W{1'b0}};
   assign intf.addr   = req_addr;
   assign intf.data_w = req_wdata;

   // Next-state for the in-flight flag, FIFO pointers and occupancy.
   always_comb begin
      inflight_d = accept && !req_we;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards any in-flight read and buffered responses.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage is not reset; contents are only visible behind resp_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= intf.data_r;
      end
   end
endmodule

// File: tb/tb_ram_client_port.sv
// Bench: two instances (response depth 2 and 4), each with its own RAM model and
// an outstanding-read scoreboard, plus table-driven and hand-written sequences.
`timescale 1ns/1ps
module tb_ram_client_port;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rsp_t;

   typedef struct {
      logic          we;
      logic [3:0]    be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          resetb;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   logic          req_valid  [2];
   logic          req_ready  [2];
   logic          req_we     [2];
   logic [3:0]    req_be     [2];
   logic [AW-1:0] req_addr   [2];
   logic [DW-1:0] req_wdata  [2];
   logic          resp_valid [2];
   logic          resp_ready [2];
   logic [DW-1:0] resp_rdata [2];
   logic          busy       [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, inst, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned DEPTH = (g == 0) ? 2 : 4;

      Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram ();

      ram_client_port #(
         .ADDR_WIDTH(AW),
         .DATA_WIDTH(DW),
         .RESP_DEPTH(DEPTH)
      ) u_dut (
         .clk        (clk),
         .resetb     (resetb),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_be     (req_be[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .busy       (busy[g]),
         .intf       (ram.client)
      );

      // Synchronous-read RAM with byte-enabled writes.
      logic [DW-1:0] mem [1024];
      always @(posedge clk) begin
         if (ram.en) begin
            if (ram.we) begin
               for (int b = 0; b < 4; b++)
                  if (ram.be[b]) mem[ram.addr][8*b +: 8] <= ram.data_w[8*b +: 8];
            end else begin
               ram.data_r <= mem[ram.addr];
            end
         end
      end

      // Reference: every accepted, not-yet-taken read is outstanding; it becomes
      // visible two cycles after acceptance; new reads need outstanding < DEPTH.
      rsp_t          q[$];
      logic [DW-1:0] mm [1024];
      always @(negedge clk) begin
         logic e_ready;
         logic e_valid;
         logic e_en;
         rsp_t r;
         if (!resetb) begin
            q.delete();
            chk("rst_ready", g, 32'(req_ready[g]), 32'd1);
            chk("rst_valid", g, 32'(resp_valid[g]), 32'd0);
            chk("rst_busy", g, 32'(busy[g]), 32'd0);
            chk("rst_en", g, 32'(ram.en), 32'(req_valid[g]));
         end else begin
            e_ready = q.size() < int'(DEPTH);
            e_valid = 1'b0;
            if (q.size() != 0) e_valid = (q[0].cyc + 2 <= cyc);
            e_en = req_valid[g] && e_ready;
            chk("ready", g, 32'(req_ready[g]), 32'(e_ready));
            chk("valid", g, 32'(resp_valid[g]), 32'(e_valid));
            chk("busy", g, 32'(busy[g]), 32'(q.size() != 0));
            chk("en", g, 32'(ram.en), 32'(e_en));
            if (e_en) begin
               chk("we", g, 32'(ram.we), 32'(req_we[g]));
               chk("be", g, 32'(ram.be), req_we[g] ? 32'(req_be[g]) : 32'd0);
               chk("addr", g, 32'(ram.addr), 32'(req_addr[g]));
               if (req_we[g]) chk("data_w", g, ram.data_w, req_wdata[g]);
            end else begin
               chk("idle_we", g, 32'(ram.we), 32'd0);
               chk("idle_be", g, 32'(ram.be), 32'd0);
            end
            if (e_valid) chk("rdata", g, resp_rdata[g], q[0].data);
            if (e_valid && resp_ready[g]) void'(q.pop_front());
            if (e_en) begin
               if (req_we[g]) begin
                  for (int b = 0; b < 4; b++)
                     if (req_be[g][b]) mm[req_addr[g]][8*b +: 8] = req_wdata[g][8*b +: 8];
               end else begin
                  r.data = mm[req_addr[g]];
                  r.cyc  = cyc;
                  q.push_back(r);
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] pf(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Advance to just after the next rising edge (the drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int i, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bit acc = 0;
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_be[i]    = be;
      req_addr[i]  = a;
      req_wdata[i] = wd;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = req_ready[i];
         step();
      end
      if (!acc) chk("accept_timeout", i, 32'd0, 32'd1);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_resp(input int i, input logic [DW-1:0] exp);
      bit got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (resp_valid[i]) begin
            got = 1;
            chk("tbl_rdata", i, resp_rdata[i], exp);
         end
         step();
      end
      if (!got) chk("resp_timeout", i, 32'd0, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [16];
      tbl[0]  = '{1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 4'h0, 10'd5, 32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 4'hF, 10'd3, 32'h0,        32'h0};
      tbl[3]  = '{1'b1, 4'h5, 10'd3, 32'h11223344, 32'h0};
      tbl[4]  = '{1'b0, 4'h0, 10'd3, 32'h0,        32'h00220044};
      tbl[5]  = '{1'b1, 4'hF, 10'd7, 32'h12345678, 32'h0};
      tbl[6]  = '{1'b1, 4'hA, 10'd7, 32'hAABBCCDD, 32'h0};
      tbl[7]  = '{1'b0, 4'h0, 10'd7, 32'h0,        32'hAA34CC78};
      tbl[8]  = '{1'b1, 4'hF, 10'd9, 32'h55667788, 32'h0};
      tbl[9]  = '{1'b1, 4'h8, 10'd9, 32'h00FFFFFF, 32'h0};
      tbl[10] = '{1'b0, 4'h0, 10'd9, 32'h0,        32'h00667788};
      tbl[11] = '{1'b1, 4'hF, 10'd0, 32'hA0A0A0A0, 32'h0};
      tbl[12] = '{1'b1, 4'hF, 10'd1, 32'hA1A1A1A1, 32'h0};
      tbl[13] = '{1'b1, 4'hF, 10'd2, 32'hA2A2A2A2, 32'h0};
      tbl[14] = '{1'b0, 4'hF, 10'd5, 32'h0,        32'hDEADBEEF};
      tbl[15] = '{1'b0, 4'h0, 10'd1, 32'h0,        32'hA1A1A1A1};

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_be[i] = '0;
         req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b1;
      end
      resetb = 1'b1;
      #2 resetb = 1'b0;
      repeat (3) @(negedge clk);
      step();
      resetb = 1'b1;

      // Table: single requests with responses consumed immediately.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 16; k++) begin
            issue(i, tbl[k].we, tbl[k].be, tbl[k].addr, tbl[k].wdata);
            if (tbl[k].we) begin
               @(negedge clk);
               chk("wr_busy", i, 32'(busy[i]), 32'd0);
               step();
               @(negedge clk);
               chk("wr_noresp", i, 32'(resp_valid[i]), 32'd0);
               step();
            end else begin
               wait_resp(i, tbl[k].exp);
            end
         end
      end

      // Single read latency: issue in cycle 0, data visible in cycle 2.
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'd5;
      @(negedge clk);
      chk("sr_en", 0, 32'(g_dut[0].ram.en), 32'd1);
      chk("sr_we", 0, 32'(g_dut[0].ram.we), 32'd0);
      chk("sr_addr", 0, 32'(g_dut[0].ram.addr), 32'd5);
      step();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("sr_c1_valid", 0, 32'(resp_valid[0]), 32'd0);
      chk("sr_c1_busy", 0, 32'(busy[0]), 32'd1);
      step();
      @(negedge clk);
      chk("sr_c2_valid", 0, 32'(resp_valid[0]), 32'd1);
      chk("sr_c2_data", 0, resp_rdata[0], 32'hDEADBEEF);
      step();
      @(negedge clk);
      chk("sr_c3_busy", 0, 32'(busy[0]), 32'd0);
      step();

      // Backpressure at depth 2: only two reads fit while responses are held.
      resp_ready[0] = 1'b0;
      req_valid[0] = 1'b1; req_addr[0] = 10'd0;
      @(negedge clk); chk("bp_acc0", 0, 32'(req_ready[0]), 32'd1); step();
      req_addr[0] = 10'd1;
      @(negedge clk); chk("bp_acc1", 0, 32'(req_ready[0]), 32'd1); step();
      req_addr[0] = 10'd2;
      @(negedge clk); chk("bp_block", 0, 32'(req_ready[0]), 32'd0); step();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("bp_hold_ready", 0, 32'(req_ready[0]), 32'd0);
         chk("bp_hold_valid", 0, 32'(resp_valid[0]), 32'd1);
         chk("bp_hold_data", 0, resp_rdata[0], 32'hA0A0A0A0);
         step();
      end
      resp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_rel_data0", 0, resp_rdata[0], 32'hA0A0A0A0);
      chk("bp_rel_ready", 0, 32'(req_ready[0]), 32'd0);
      step();
      @(negedge clk);
      chk("bp_acc2", 0, 32'(req_ready[0]), 32'd1);
      chk("bp_rel_data1", 0, resp_rdata[0], 32'hA1A1A1A1);
      step();
      req_valid[0] = 1'b0;
      @(negedge clk); chk("bp_gap", 0, 32'(resp_valid[0]), 32'd0); step();
      @(negedge clk);
      chk("bp_data2_valid", 0, 32'(resp_valid[0]), 32'd1);
      chk("bp_data2", 0, resp_rdata[0], 32'hA2A2A2A2);
      step();
      @(negedge clk); chk("bp_idle", 0, 32'(busy[0]), 32'd0); step();

      // Simultaneous push and pop with one buffered and one in flight.
      resp_ready[0] = 1'b0;
      req_valid[0] = 1'b1; req_addr[0] = 10'd0;
      @(negedge clk); chk("pp_acc0", 0, 32'(req_ready[0]), 32'd1); step();
      req_addr[0] = 10'd1;
      @(negedge clk); chk("pp_acc1", 0, 32'(req_ready[0]), 32'd1); step();
      req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
      @(negedge clk);
      chk("pp_c2_data", 0, resp_rdata[0], 32'hA0A0A0A0);
      chk("pp_c2_ready", 0, 32'(req_ready[0]), 32'd0);
      step();
      @(negedge clk);
      chk("pp_c3_valid", 0, 32'(resp_valid[0]), 32'd1);
      chk("pp_c3_data", 0, resp_rdata[0], 32'hA1A1A1A1);
      chk("pp_c3_ready", 0, 32'(req_ready[0]), 32'd1);
      step();
      @(negedge clk); chk("pp_c4_valid", 0, 32'(resp_valid[0]), 32'd0); step();

      // Prefill a known pattern for streaming and random traffic.
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 32; a++) issue(i, 1'b1, 4'hF, 10'(a), pf(a));

      // Streaming at depth 4: one read per cycle, responses in address order.
      for (int k = 0; k < 18; k++) begin
         req_valid[1] = (k < 16); req_we[1] = 1'b0; req_addr[1] = 10'(k & 15);
         @(negedge clk);
         if (k < 16) chk("st_ready", 1, 32'(req_ready[1]), 32'd1);
         if (k >= 2) begin
            chk("st_valid", 1, 32'(resp_valid[1]), 32'd1);
            chk("st_data", 1, resp_rdata[1], pf(k - 2));
         end
         step();
      end
      @(negedge clk); chk("st_end", 1, 32'(resp_valid[1]), 32'd0); step();

      // Reset while a read is in flight: nothing may come back afterwards.
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'd5;
      @(negedge clk); chk("rr_acc", 0, 32'(req_ready[0]), 32'd1); step();
      req_valid[0] = 1'b0;
      resetb = 1'b0;
      @(negedge clk); step();
      resetb = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("rr_valid", 0, 32'(resp_valid[0]), 32'd0);
         chk("rr_busy", 0, 32'(busy[0]), 32'd0);
         chk("rr_ready", 0, 32'(req_ready[0]), 32'd1);
         step();
      end

      // Random traffic on both instances against the scoreboards.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            req_valid[i]  = ($urandom_range(0, 9) < 7);
            req_we[i]     = ($urandom_range(0, 9) < 3);
            req_be[i]     = 4'($urandom);
            req_addr[i]   = 10'($urandom_range(0, 31));
            req_wdata[i]  = $urandom;
            resp_ready[i] = ($urandom_range(0, 9) < 6);
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; resp_ready[i] = 1'b1;
      end
      repeat (8) step();
      @(negedge clk);
      chk("drain_busy", 0, 32'(busy[0]), 32'd0);
      chk("drain_busy", 1, 32'(busy[1]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
